jpeg_frame_ctrl: RTL and testbench
==================================

Name: jpeg_frame_ctrl

Overview:
- Frame-level sequencer wrapped around jpeg_pipeline.
- Fetches an 8-bit greyscale image from memory as 32-bit words and feeds the pipeline one pixel per handshake in raster order.
- Counts finished blocks, issues done_image, waits for the flush, then packs the variable-width output bytes into 32-bit words and writes them to a destination buffer.
- Software sees start/busy/done and a byte count.

Parameters:
- ADDR_W, 32, width of byte addresses on both memory ports.
- DIM_W, 12, width of the width_px/height_px inputs.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- src_base  in  ADDR_W  byte address of pixel 0; word-aligned.
- dst_base  in  ADDR_W  byte address of output; word-aligned.
- width_px  in  DIM_W  image width; multiple of 8.
- height_px  in  DIM_W  image height; multiple of 8.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at frame end.
- byte_count  out  ADDR_W  output bytes written for the last/current frame.
- rd_req  out  1  read request; held until rd_ack.
- rd_addr  out  ADDR_W  read word address.
- rd_ack  in  1  read complete; rd_data valid this cycle.
- rd_data  in  32  pixels; byte 0 = lowest address.
- wr_req  out  1  write request; held until wr_ack.
- wr_addr  out  ADDR_W  write word address.
- wr_data  out  32  packed output bytes.
- wr_be  out  4  byte enables.
- wr_ack  in  1  write accepted.
- pix  out  8  pixel to pipeline in_pixel.
- pix_ena  out  1  pixel valid (pipeline ena_in).
- pix_rdy  in  1  pipeline rdy_out.
- bits  in  16  pipeline out_bits; byte in [15:8] is first.
- bits_valid  in  2  0/1/2 valid bytes; 1 means [15:8] only.
- bits_ena  in  1  pipeline ena_out.
- bits_rdy  out  1  to pipeline rdy_in.
- done_image  out  1  to pipeline.
- done_block  in  1  pipeline per-block pulse.
- done_flush  in  1  pipeline flush-complete pulse.

Behaviour:
- Reset: all outputs 0 except bits_rdy=1; FSM=IDLE. Reset asserted mid-frame aborts immediately and drops any partial word.
- Handshakes: pixel/bits transfers occur on a cycle with ena&&rdy. Memory requests hold address/data stable until ack.
- FSM states:
  - IDLE: on start, latch parameters, clear byte_count, busy<=1. If width_px==0 or height_px==0, go to FINISH (no pipeline activity). Otherwise go to FETCH. Start while busy is ignored.
  - FETCH: rd_req at src_base+4*k. On rd_ack, latch the word and go to FEED.
  - FEED: pix_ena=1, present bytes 0..3 in order, advance on each transfer. After byte 3, go to FETCH, or to WAIT_BLK if total pixels have been sent.
  - WAIT_BLK: stay until the done_block count equals (width_px/8)*(height_px/8). done_block is counted in every state. Then pulse done_image for 1 cycle and go to WAIT_FLUSH.
  - WAIT_FLUSH: stay until done_flush. Then go to TAIL.
  - TAIL: if the assembler holds n>0 bytes, write them with wr_be low n bits set and unused bytes 0.
  - FINISH: busy<=0, done pulse, back to IDLE.
- Output packer:
  - 4-byte assembler plus one hold register.
  - bits_rdy = !hold_valid.
  - On accept, append bits_valid bytes. When 4 bytes complete, move the word to hold and keep any overflow byte in the assembler.
  - hold_valid drives wr_req at dst_base+4*w. Clear hold on wr_ack; hold and ack may turn over in the same cycle.
  - byte_count increments by accepted bytes.
  - Output is accepted in all non-IDLE states, including the done_flush cycle.
- Latency: first pix_ena no earlier than 2 cycles after start (start→FETCH→first rd_ack).

Optional Feature:
- Macro: JPEG_EOI_EN.
- Defined: after done_flush, append bytes 0xFF,0xD9 into the packer before TAIL; byte_count includes them.
- Undefined: no marker; software appends EOI.

Decomposition:
- Package jpeg_ctrl_pkg holds the FSM state enum and the constants EOI_HI=8'hFF, EOI_LO=8'hD9.
- Sub-module jpeg_byte_packer: assembler, hold register, write-port logic and byte_count. The FSM only sequences.

Test Plan:
- 8x8 image, pixels 0..63, memory ack in 1 cycle:
  - 16 reads at src_base+0..60.
  - pix sequence 0..63 in order.
  - done_image exactly once, after the 1st done_block.
  - done pulses after done_flush.
- Packer model feeding bits_valid 2,1,2,2 (7 bytes):
  - One full write with wr_be=4'hF.
  - Tail write with wr_be=4'h7.
  - byte_count=7 (9 with JPEG_EOI_EN, tail bytes …FF,D9).
- wr_ack withheld 20 cycles with hold full:
  - bits_rdy=0 throughout; no byte lost or duplicated.
- pix_rdy toggled randomly at 16x16 size:
  - pix order preserved.
  - done_image only after 4 done_block pulses.
- width_px=0:
  - done 1 cycle after FINISH; no rd_req, pix_ena or done_image; byte_count=0.
- rst_n low during FEED:
  - all outputs 0 asynchronously, bits_rdy=1.
  - A new start after release runs a clean frame.

Source files
------------

// File: rtl/jpeg_ctrl_pkg.sv
// Shared types and constants for the JPEG frame controller.
// The end-of-image marker bytes are used only when JPEG_EOI_EN is defined.
package jpeg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_FEED       = 3'd2,
        ST_WAIT_BLK   = 3'd3,
        ST_WAIT_FLUSH = 3'd4,
        ST_EOI        = 3'd5,
        ST_TAIL       = 3'd6,
        ST_FINISH     = 3'd7
    } ctrl_state_t;

    localparam logic [7:0] EOI_HI = 8'hFF;
    localparam logic [7:0] EOI_LO = 8'hD9;

    // Byte-enable mask with the low n lanes set.
    function automatic logic [3:0] be_mask(input logic [1:0] n);
        logic [3:0] m;
        case (n)
            2'd1:    m = 4'h1;
            2'd2:    m = 4'h3;
            2'd3:    m = 4'h7;
            default: m = 4'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/jpeg_byte_packer.sv
// Output byte packer: gathers 0..2 bytes per accepted beat into 32-bit
// words, holds one finished word for the write port and counts bytes.
// An insert port lets the sequencer push the EOI marker (JPEG_EOI_EN builds).
module jpeg_byte_packer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              active,
    input  logic [15:0]       bits,
    input  logic [1:0]        bits_valid,
    input  logic              bits_ena,
    output logic              bits_rdy,
    input  logic              ins_ena,
    output logic              ins_ack,
    input  logic              flush,
    output logic              empty,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] byte_count
);
    import jpeg_ctrl_pkg::*;

    // Assembler bytes above asm_cnt are always kept at zero so that a
    // partial tail word goes out with its unused lanes cleared.
    logic [23:0]       asm_q;
    logic [1:0]        asm_cnt;
    logic              hold_valid;
    logic [31:0]       hold_data;
    logic [3:0]        hold_be;
    logic [ADDR_W-1:0] wcnt;

    logic              bits_acc;
    logic              flush_go;
    logic [1:0]        in_n;
    logic [15:0]       in_bytes;
    logic [2:0]        total;
    logic [39:0]       cat;

    assign bits_rdy = !hold_valid && !ins_ena;
    assign ins_ack  = ins_ena && !hold_valid;
    assign bits_acc = active && bits_ena && bits_rdy;

    // Select the incoming bytes; first byte lands in the low lane.
    always_comb begin
        in_n     = 2'd0;
        in_bytes = 16'h0000;
        if (ins_ack) begin
            in_n     = 2'd2;
            in_bytes = {EOI_LO, EOI_HI};
        end else if (bits_acc) begin
            case (bits_valid)
                2'd1:    begin in_n = 2'd1; in_bytes = {8'h00, bits[15:8]};       end
                2'd2,
                2'd3:    begin in_n = 2'd2; in_bytes = {bits[7:0], bits[15:8]};   end
                default: begin in_n = 2'd0; in_bytes = 16'h0000;                  end
            endcase
        end
    end

    assign total    = {1'b0, asm_cnt} + {1'b0, in_n};
    assign cat      = {16'h0000, asm_q} | ({24'h000000, in_bytes} << {asm_cnt, 3'b000});
    assign flush_go = flush && !hold_valid && (in_n == 2'd0) && (asm_cnt != 2'd0);
    assign empty    = !hold_valid && (asm_cnt == 2'd0) && (in_n == 2'd0);

    // Assembler, hold register, write-word counter and byte count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q      <= '0;
            asm_cnt    <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_be    <= '0;
            wcnt       <= '0;
            byte_count <= '0;
        end else if (clr) begin
            asm_q      <= '0;
            asm_cnt    <= '0;
            hold_valid <= 1'b0;
            hold_be    <= '0;
            wcnt       <= '0;
            byte_count <= '0;
        end else begin
            if (hold_valid && wr_ack) begin
                hold_valid <= 1'b0;
                wcnt       <= wcnt + 1'b1;
            end
            if (total >= 3'd4) begin
                hold_data  <= cat[31:0];
                hold_be    <= 4'hF;
                hold_valid <= 1'b1;
                asm_q      <= {16'h0000, cat[39:32]};
                asm_cnt    <= total[1:0];
            end else if (flush_go) begin
                hold_data  <= {8'h00, asm_q};
                hold_be    <= be_mask(asm_cnt);
                hold_valid <= 1'b1;
                asm_q      <= '0;
                asm_cnt    <= '0;
            end else if (in_n != 2'd0) begin
                asm_q   <= cat[23:0];
                asm_cnt <= total[1:0];
            end
            byte_count <= byte_count + ADDR_W'(in_n);
        end
    end

    assign wr_req  = hold_valid;
    assign wr_addr = dst_base + (wcnt << 2);
    assign wr_data = hold_data;
    assign wr_be   = hold_be;

endmodule

// File: rtl/jpeg_frame_ctrl.sv
// Frame sequencer around jpeg_pipeline: fetches pixel words, feeds pixels
// in raster order, waits for blocks and flush, then drains the packer.
// Optional macro JPEG_EOI_EN appends the FF D9 end-of-image marker.
//
// state         | meaning
// --------------+----------------------------------------------
// ST_IDLE       | waiting for start
// ST_FETCH      | read request for the next source word
// ST_FEED       | presenting the four pixels of the latched word
// ST_WAIT_BLK   | all pixels sent, waiting for the last done_block
// ST_WAIT_FLUSH | done_image issued, waiting for done_flush
// ST_EOI        | inserting the EOI marker (JPEG_EOI_EN only)
// ST_TAIL       | writing out any partial word
// ST_FINISH     | frame end, done pulse follows
module jpeg_frame_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  width_px,
    input  logic [DIM_W-1:0]  height_px,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_count,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [31:0]       rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be,
    input  logic              wr_ack,
    output logic [7:0]        pix,
    output logic              pix_ena,
    input  logic              pix_rdy,
    input  logic [15:0]       bits,
    input  logic [1:0]        bits_valid,
    input  logic              bits_ena,
    output logic              bits_rdy,
    output logic              done_image,
    input  logic              done_block,
    input  logic              done_flush
);
    import jpeg_ctrl_pkg::*;

    localparam int CNT_W = 2 * DIM_W;

    ctrl_state_t       state, nxt;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [CNT_W-1:0]  word_total, blk_total, word_k, blk_cnt;
    logic [CNT_W-1:0]  px_total, blk_calc;
    logic [1:0]        byte_sel;
    logic [31:0]       word_q;
    logic              accept, dim_zero, pix_xfer, last_byte;
    logic              ins_ena, ins_ack, tail_flush, pk_empty, img_set;

    assign accept    = (state == ST_IDLE) && start;
    assign dim_zero  = (width_px == '0) || (height_px == '0);
    assign pix_xfer  = (state == ST_FEED) && pix_rdy;
    assign last_byte = (byte_sel == 2'd3);
    assign px_total  = CNT_W'(width_px) * CNT_W'(height_px);
    assign blk_calc  = CNT_W'(width_px[DIM_W-1:3]) * CNT_W'(height_px[DIM_W-1:3]);

    assign rd_req  = (state == ST_FETCH);
    assign rd_addr = src_q + (ADDR_W'(word_k) << 2);
    assign pix_ena = (state == ST_FEED);
    assign pix     = pix_ena ? word_q[{byte_sel, 3'b000} +: 8] : 8'h00;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    // Next-state decode and sequencing strobes.
    always_comb begin
        nxt        = state;
        ins_ena    = 1'b0;
        tail_flush = 1'b0;
        img_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) nxt = dim_zero ? ST_FINISH : ST_FETCH;
            end
            ST_FETCH: begin
                if (rd_ack) nxt = ST_FEED;
            end
            ST_FEED: begin
                if (pix_rdy && last_byte)
                    nxt = (word_k == word_total - 1'b1) ? ST_WAIT_BLK : ST_FETCH;
            end
            ST_WAIT_BLK: begin
                if (blk_cnt == blk_total) begin
                    img_set = 1'b1;
                    nxt     = ST_WAIT_FLUSH;
                end
            end
            ST_WAIT_FLUSH: begin
                if (done_flush) begin
`ifdef JPEG_EOI_EN
                    nxt = ST_EOI;
`else
                    nxt = ST_TAIL;
`endif
                end
            end
            ST_EOI: begin
                ins_ena = 1'b1;
                if (ins_ack) nxt = ST_TAIL;
            end
            ST_TAIL: begin
                tail_flush = 1'b1;
                if (pk_empty) nxt = ST_FINISH;
            end
            ST_FINISH: begin
                nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Frame parameters latched on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            dst_q      <= '0;
            word_total <= '0;
            blk_total  <= '0;
        end else if (accept) begin
            src_q      <= src_base;
            dst_q      <= dst_base;
            word_total <= px_total >> 2;
            blk_total  <= blk_calc;
        end
    end

    // Source word, byte pointer and word index for the pixel feed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            byte_sel <= '0;
            word_k   <= '0;
        end else if (accept) begin
            byte_sel <= '0;
            word_k   <= '0;
        end else if ((state == ST_FETCH) && rd_ack) begin
            word_q   <= rd_data;
            byte_sel <= '0;
        end else if (pix_xfer) begin
            byte_sel <= byte_sel + 1'b1;
            if (last_byte) word_k <= word_k + 1'b1;
        end
    end

    // done_block counter; pulses may arrive in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          blk_cnt <= '0;
        else if (accept)     blk_cnt <= '0;
        else if (done_block) blk_cnt <= blk_cnt + 1'b1;
    end

    // Status outputs: busy level, done and done_image pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            done_image <= 1'b0;
        end else begin
            done_image <= img_set;
            done       <= (state == ST_FINISH);
            if (accept)                  busy <= 1'b1;
            else if (state == ST_FINISH) busy <= 1'b0;
        end
    end

    jpeg_byte_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept),
        .active     (state != ST_IDLE),
        .bits       (bits),
        .bits_valid (bits_valid),
        .bits_ena   (bits_ena),
        .bits_rdy   (bits_rdy),
        .ins_ena    (ins_ena),
        .ins_ack    (ins_ack),
        .flush      (tail_flush),
        .empty      (pk_empty),
        .dst_base   (dst_q),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_ack     (wr_ack),
        .byte_count (byte_count)
    );

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Directed bench for jpeg_frame_ctrl with memory, pipeline and writer models.
module tb_jpeg_frame_ctrl;

    localparam int ADDR_W = 32;
    localparam int DIM_W  = 12;
    localparam logic [31:0] SRC = 32'h0000_1000;
    localparam logic [31:0] DST = 32'h0000_2000;

`ifdef JPEG_EOI_EN
    localparam int NW = 3;
    localparam int BC = 9;
`else
    localparam int NW = 2;
    localparam int BC = 7;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] src_base, dst_base;
    logic [DIM_W-1:0]  width_px, height_px;
    logic              busy, done;
    logic [ADDR_W-1:0] byte_count;
    logic              rd_req, rd_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              wr_req, wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic [7:0]        pix;
    logic              pix_ena, pix_rdy;
    logic [15:0]       bits;
    logic [1:0]        bits_valid;
    logic              bits_ena, bits_rdy;
    logic              done_image, done_block, done_flush;

    jpeg_frame_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_base(src_base), .dst_base(dst_base),
        .width_px(width_px), .height_px(height_px),
        .busy(busy), .done(done), .byte_count(byte_count),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
        .pix(pix), .pix_ena(pix_ena), .pix_rdy(pix_rdy),
        .bits(bits), .bits_valid(bits_valid), .bits_ena(bits_ena), .bits_rdy(bits_rdy),
        .done_image(done_image), .done_block(done_block), .done_flush(done_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state.
    int rd_n, pix_n, blk_req, blk_sent, img_n, img_blk, done_n, done_early, wr_n;
    int rd_seen, pix_seen;
    bit pix_rand, pix_stall, wr_block, flush_sent;
    logic [31:0] wd [8];
    logic [3:0]  wb [8];
    logic [31:0] wa [8];
    logic [31:0] off;
    logic [31:0] exp_wd [3];
    logic [3:0]  exp_wb [3];

    task automatic clear_counters();
        rd_n = 0; pix_n = 0; blk_req = 0; blk_sent = 0; img_n = 0; img_blk = 0;
        done_n = 0; done_early = 0; wr_n = 0; rd_seen = 0; pix_seen = 0;
        flush_sent = 0; wr_block = 0;
        for (int i = 0; i < 8; i++) begin wd[i] = '0; wb[i] = '0; wa[i] = '0; end
    endtask

    // Observe handshakes between edges; each transfer completes at the next posedge.
    always @(negedge clk) begin
        if (rd_req) rd_seen++;
        if (pix_ena) pix_seen++;
        if (rd_req && rd_ack) begin
            check_val("rd_addr", rd_addr, SRC + 32'(4 * rd_n));
            rd_n++;
        end
        if (pix_ena && pix_rdy) begin
            check_val("pix_order", {24'h0, pix}, 32'(pix_n & 255));
            pix_n++;
            if (pix_n % 64 == 0) blk_req++;
        end
        if (done_image) begin img_n++; img_blk = blk_sent; end
        if (done) begin done_n++; if (!flush_sent) done_early++; end
        if (wr_req && wr_ack) begin
            if (wr_n < 8) begin wd[wr_n] = wr_data; wb[wr_n] = wr_be; wa[wr_n] = wr_addr; end
            wr_n++;
        end
    end

    // Memory, pipeline-input and writer responders, driven just after each edge.
    always @(posedge clk) begin
        #1;
        rd_ack  = rd_req;
        off     = rd_addr - SRC;
        rd_data = {8'(off + 3), 8'(off + 2), 8'(off + 1), 8'(off)};
        pix_rdy = pix_stall ? 1'b0 : (pix_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        wr_ack  = wr_req && !wr_block;
        if (blk_sent < blk_req && !done_block) begin
            done_block = 1'b1;
            blk_sent++;
        end else begin
            done_block = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctl"}, {25'h0, busy, done, rd_req, wr_req, pix_ena, done_image, bits_rdy}, 32'h1);
        check_val({tag, "_addr"}, rd_addr | wr_addr, 32'h0);
        check_val({tag, "_data"}, wr_data, 32'h0);
        check_val({tag, "_misc"}, {20'h0, wr_be, pix}, 32'h0);
        check_val({tag, "_bc"}, byte_count, 32'h0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_entry(input logic [15:0] b, input logic [1:0] n);
        int t = 0;
        bits = b; bits_valid = n; bits_ena = 1'b1;
        @(negedge clk);
        while (!bits_rdy && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) check_val("bits_timeout", 32'(t), 32'h0);
        @(posedge clk); #1;
        bits_ena = 1'b0; bits = '0; bits_valid = '0;
    endtask

    task automatic run_frame(input int w, input int h, input bit rnd, input bit hold);
        int t;
        int bad;
        clear_counters();
        pix_rand = rnd;
        width_px = DIM_W'(w); height_px = DIM_W'(h);
        src_base = SRC; dst_base = DST;
        pulse_start();
        t = 0;
        while (img_n == 0 && t < 20000) begin @(posedge clk); #1; t++; end
        check_val("img_wait", 32'(img_n), 32'h1);
        wr_block = hold;
        send_entry(16'hA1B2, 2'd2);
        send_entry(16'hC35A, 2'd1);
        send_entry(16'hD4E5, 2'd2);
        if (hold) begin
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bits_rdy || !wr_req) bad++;
            end
            check_val("stall_rdy", 32'(bad), 32'h0);
            check_val("stall_nowr", 32'(wr_n), 32'h0);
            @(posedge clk); #1;
            wr_block = 1'b0;
        end
        send_entry(16'hF6A7, 2'd2);
        done_flush = 1'b1; flush_sent = 1'b1;
        @(posedge clk); #1;
        done_flush = 1'b0;
        t = 0;
        while (done_n == 0 && t < 200) begin @(posedge clk); #1; t++; end
        repeat (3) @(posedge clk);
        #1;
        check_val("reads", 32'(rd_n), 32'(w * h / 4));
        check_val("pixels", 32'(pix_n), 32'(w * h));
        check_val("img_once", 32'(img_n), 32'h1);
        check_val("img_after_blk", 32'(img_blk), 32'(w * h / 64));
        check_val("done_once", 32'(done_n), 32'h1);
        check_val("done_after_flush", 32'(done_early), 32'h0);
        check_val("wr_count", 32'(wr_n), 32'(NW));
        for (int i = 0; i < NW; i++) begin
            check_val("wr_data", wd[i], exp_wd[i]);
            check_val("wr_be", {28'h0, wb[i]}, {28'h0, exp_wb[i]});
            check_val("wr_addr", wa[i], DST + 32'(4 * i));
        end
        check_val("byte_count", byte_count, 32'(BC));
        check_val("busy_end", {31'h0, busy}, 32'h0);
    endtask

    task automatic run_zero();
        clear_counters();
        width_px = '0; height_px = DIM_W'(8);
        pulse_start();
        @(negedge clk);
        check_val("zero_fin", {30'h0, busy, done}, 32'h2);
        @(negedge clk);
        check_val("zero_done", {30'h0, busy, done}, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        check_val("zero_quiet", 32'(rd_seen + pix_seen + img_n), 32'h0);
        check_val("zero_done_n", 32'(done_n), 32'h1);
        check_val("zero_bc", byte_count, 32'h0);
    endtask

    task automatic run_reset_abort();
        int t = 0;
        clear_counters();
        pix_stall = 1'b1;
        width_px = DIM_W'(8); height_px = DIM_W'(8);
        pulse_start();
        while (!pix_ena && t < 50) begin @(negedge clk); t++; end
        check_val("abort_in_feed", {31'h0, pix_ena}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix_stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0;
        src_base = '0; dst_base = '0; width_px = '0; height_px = '0;
        rd_ack = 1'b0; rd_data = '0; wr_ack = 1'b0; pix_rdy = 1'b1;
        bits = '0; bits_valid = '0; bits_ena = 1'b0;
        done_block = 1'b0; done_flush = 1'b0;
        pix_rand = 1'b0; pix_stall = 1'b0;
        clear_counters();
`ifdef JPEG_EOI_EN
        exp_wd[0] = 32'hD4C3B2A1; exp_wb[0] = 4'hF;
        exp_wd[1] = 32'hFFA7F6E5; exp_wb[1] = 4'hF;
        exp_wd[2] = 32'h000000D9; exp_wb[2] = 4'h1;
`else
        exp_wd[0] = 32'hD4C3B2A1; exp_wb[0] = 4'hF;
        exp_wd[1] = 32'h00A7F6E5; exp_wb[1] = 4'h7;
        exp_wd[2] = 32'h00000000; exp_wb[2] = 4'h0;
`endif
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_frame(8, 8, 1'b0, 1'b0);
        run_frame(8, 8, 1'b0, 1'b1);
        run_frame(16, 16, 1'b1, 1'b0);
        run_zero();
        run_reset_abort();
        run_frame(8, 8, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
